// File: rtl/x25519_ladder_control.sv
// Sequencer for the X25519 Montgomery ladder: drives one iteration block per scalar bit, 254 down to 0.
// Define X25519_CLAMP_EN to apply the RFC 7748 clamp to the scalar when it is latched.
module x25519_ladder_control (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [255:0] e,
  input  logic [263:0] work_low,
  output logic         busy,
  output logic         out_valid,
  output logic [511:0] xzm_out,
  output logic         iter_en,
  output logic [511:0] iter_xzm_in,
  output logic [511:0] iter_xzm1_in,
  output logic         iter_b,
  output logic [263:0] iter_work_low,
  input  logic         iter_out_valid,
  input  logic [511:0] iter_xzm_out,
  input  logic [511:0] iter_xzm1_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t       state, state_next;
  logic [7:0]   pos;
  logic [255:0] scalar;
  logic [255:0] scalar_in;
  logic         start;
  logic         capture;
  logic         last;

`ifdef X25519_CLAMP_EN
  localparam logic [255:0] CLAMP_CLR = {1'b1, 1'b0, 251'd0, 3'b111};
  localparam logic [255:0] CLAMP_SET = {1'b0, 1'b1, 254'd0};
  assign scalar_in = (e & ~CLAMP_CLR) | CLAMP_SET;
`else
  assign scalar_in = e;
`endif

  assign start   = (state == IDLE) && en;
  assign capture = (state == WAIT) && iter_out_valid;
  assign last    = (pos == 8'd0);
  assign iter_b  = scalar[pos];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Results arriving outside WAIT are ignored, which drops stale results after a reset.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    out_valid  = 1'b0;
    iter_en    = 1'b0;
    case (state)
      IDLE: begin
        if (en) state_next = ISSUE;
      end
      ISSUE: begin
        busy       = 1'b1;
        iter_en    = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (iter_out_valid) state_next = last ? DONE : ISSUE;
      end
      DONE: begin
        out_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The final result is loaded on the same edge that enters DONE, so it is visible with out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos           <= 8'd0;
      scalar        <= 256'd0;
      iter_xzm_in   <= 512'd0;
      iter_xzm1_in  <= 512'd0;
      iter_work_low <= 264'd0;
      xzm_out       <= 512'd0;
    end else begin
      if (start) begin
        scalar        <= scalar_in;
        iter_work_low <= work_low;
        iter_xzm_in   <= {256'd0, 256'd1};
        iter_xzm1_in  <= {256'd1, work_low[255:0]};
        pos           <= 8'd254;
      end
      if (capture) begin
        iter_xzm_in  <= iter_xzm_out;
        iter_xzm1_in <= iter_xzm1_out;
        if (last) begin
          xzm_out <= iter_xzm_out;
        end else begin
          pos <= pos - 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_x25519_ladder_control.sv
// Bench for x25519_ladder_control: table-driven runs against stub and model iteration blocks,
// plus reset/stale-result, busy-poke, DONE-cycle and RFC 7748 end-to-end sequences.
module tb_x25519_ladder_control;

  localparam logic [255:0] P = {1'b0, {250{1'b1}}, 5'b01101};

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [255:0] e;
  logic [263:0] work_low;
  logic         busy;
  logic         out_valid;
  logic [511:0] xzm_out;
  logic         iter_en;
  logic [511:0] iter_xzm_in;
  logic [511:0] iter_xzm1_in;
  logic         iter_b;
  logic [263:0] iter_work_low;
  logic         iter_out_valid = 1'b0;
  logic [511:0] iter_xzm_out = 512'd0;
  logic [511:0] iter_xzm1_out = 512'd0;

  x25519_ladder_control dut (
    .clk(clk), .rst(rst), .en(en), .e(e), .work_low(work_low),
    .busy(busy), .out_valid(out_valid), .xzm_out(xzm_out),
    .iter_en(iter_en), .iter_xzm_in(iter_xzm_in), .iter_xzm1_in(iter_xzm1_in),
    .iter_b(iter_b), .iter_work_low(iter_work_low),
    .iter_out_valid(iter_out_valid), .iter_xzm_out(iter_xzm_out), .iter_xzm1_out(iter_xzm1_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Field arithmetic modulo 2^255-19 for the reference ladder step.
  function automatic logic [255:0] fadd(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[255:0];
  endfunction

  function automatic logic [255:0] fsub(input logic [255:0] a, input logic [255:0] b);
    if (a >= b) return a - b;
    return a + P - b;
  endfunction

  function automatic logic [255:0] fmul(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] t;
    t = {256'd0, a} * {256'd0, b};
    t = t % {256'd0, P};
    return t[255:0];
  endfunction

  function automatic logic [255:0] finv(input logic [255:0] z);
    logic [255:0] r;
    logic [255:0] ex;
    r  = 256'd1;
    ex = P - 256'd2;
    for (int i = 255; i >= 0; i--) begin
      r = fmul(r, r);
      if (ex[i]) r = fmul(r, z);
    end
    return r;
  endfunction

  // Returns {xzm1_next, xzm_next}; swap in by b, RFC 7748 step, swap back.
  function automatic logic [1023:0] ladder_step(input logic [511:0] xzm, input logic [511:0] xzm1,
                                                input logic b, input logic [255:0] u);
    logic [255:0] x2, z2, x3, z3, a, aa, bv, bb, ee, c, d, da, cb, nx2, nz2, nx3, nz3, t;
    x2 = xzm[255:0];  z2 = xzm[511:256];
    x3 = xzm1[255:0]; z3 = xzm1[511:256];
    if (b) begin
      t = x2; x2 = x3; x3 = t;
      t = z2; z2 = z3; z3 = t;
    end
    a  = fadd(x2, z2); aa = fmul(a, a);
    bv = fsub(x2, z2); bb = fmul(bv, bv);
    ee = fsub(aa, bb);
    c  = fadd(x3, z3); d = fsub(x3, z3);
    da = fmul(d, a);   cb = fmul(c, bv);
    t   = fadd(da, cb); nx3 = fmul(t, t);
    t   = fsub(da, cb); nz3 = fmul(u, fmul(t, t));
    nx2 = fmul(aa, bb);
    nz2 = fmul(ee, fadd(aa, fmul(256'd121665, ee)));
    if (b) return {nz2, nx2, nz3, nx3};
    return {nz3, nx3, nz2, nx2};
  endfunction

  function automatic logic [255:0] bswap(input logic [255:0] v);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = v[8*(31-i) +: 8];
    return r;
  endfunction

  function automatic logic [255:0] model_scalar(input logic [255:0] k);
    logic [255:0] r;
    r = k;
`ifdef X25519_CLAMP_EN
    r[2:0] = 3'b000;
    r[255] = 1'b0;
    r[254] = 1'b1;
`endif
    return r;
  endfunction

  // Iteration-block responder (mode 0 pass-through, 1 increment, 2 reference ladder) and monitor.
  int lat = 1;
  int mode = 0;
  int stale_req = 0;
  int stale_done = 0;
  int issue_count = 0;
  int ov_count = 0;
  int busy_count = 0;
  int stab_viol = 0;
  int ov_cyc = 0;
  logic busy_at_ov = 1'b0;
  logic b_q[$];
  logic [511:0] xin_q[$];
  logic [511:0] x1in_q[$];
  logic [263:0] wl_q[$];
  int pending = 0;
  int countdown = 0;
  logic [511:0] cap_xzm, cap_xzm1, res_xzm, res_xzm1;
  logic [263:0] cap_wl;
  logic         cap_b;
  logic [1023:0] step;
  logic [255:0] u_red;

  always @(negedge clk) begin
    if (pending != 0 && busy) begin
      if (iter_b !== cap_b || iter_xzm_in !== cap_xzm || iter_xzm1_in !== cap_xzm1 ||
          iter_work_low !== cap_wl) stab_viol++;
    end
    iter_out_valid = 1'b0;
    if (stale_req != stale_done) begin
      stale_done     = stale_req;
      iter_out_valid = 1'b1;
      iter_xzm_out   = {16{32'hDEADBEEF}};
      iter_xzm1_out  = {16{32'hCAFEF00D}};
    end else if (pending != 0) begin
      countdown--;
      if (countdown == 0) begin
        pending        = 0;
        iter_out_valid = 1'b1;
        iter_xzm_out   = res_xzm;
        iter_xzm1_out  = res_xzm1;
      end
    end
    if (iter_en) begin
      issue_count++;
      b_q.push_back(iter_b);
      xin_q.push_back(iter_xzm_in);
      x1in_q.push_back(iter_xzm1_in);
      wl_q.push_back(iter_work_low);
      cap_b = iter_b; cap_xzm = iter_xzm_in; cap_xzm1 = iter_xzm1_in; cap_wl = iter_work_low;
      pending   = 1;
      countdown = lat;
      if (mode == 1) begin
        res_xzm  = iter_xzm_in + 512'd1;
        res_xzm1 = iter_xzm1_in + 512'd2;
      end else if (mode == 2) begin
        u_red = iter_work_low[255:0];
        if (u_red >= P) u_red = u_red - P;
        step     = ladder_step(iter_xzm_in, iter_xzm1_in, iter_b, u_red);
        res_xzm  = step[511:0];
        res_xzm1 = step[1023:512];
      end else begin
        res_xzm  = iter_xzm_in;
        res_xzm1 = iter_xzm1_in;
      end
    end
    if (busy) busy_count++;
    if (out_valid) begin
      ov_count++;
      ov_cyc     = cyc;
      busy_at_ov = busy;
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    string        name;
    logic [255:0] e;
    logic [263:0] wl;
    int           lat;
    int           mode;
    int           exp_ones;
    logic         exp_first;
    logic         exp_last;
    logic [511:0] exp_xzm;
    int           busy_poke;
    bit           done_poke;
  } vec_t;

  vec_t vecs[5];
  vec_t ve;
  int n_vec = 0;
  int n_err = 0;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  // Runs one complete operation from an IDLE cycle; caller sits just after a falling edge.
  task automatic applyStimulus(input vec_t v);
    int ib, bb, sv, en_cyc, guard, limit, nb_err, ones;
    logic [255:0] ks;
    bit poked;
    ib = issue_count; bb = busy_count; sv = stab_viol;
    lat = v.lat; mode = v.mode;
    e = v.e; work_low = v.wl; en = 1'b1; en_cyc = cyc;
    @(negedge clk); #1;
    en = 1'b0;
    limit = 255 * (v.lat + 1) + 40;
    guard = 0; poked = 0;
    while (!out_valid && guard < limit) begin
      if (v.busy_poke >= 0 && !poked && (issue_count - ib) == v.busy_poke) begin
        en = 1'b1; e = ~v.e; work_low = ~v.wl; poked = 1;
      end else begin
        en = 1'b0;
      end
      @(negedge clk); #1;
      guard++;
    end
    if (!out_valid) checkOutput({v.name, " out_valid timeout"}, 0, 1);
    if (v.done_poke) begin
      en = 1'b1; e = ~v.e;
    end
    @(negedge clk); #1;
    en = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
    end
    checkOutput({v.name, " iter_en count"}, issue_count - ib, 255);
    ks = model_scalar(v.e);
    nb_err = 0; ones = 0;
    for (int i = 0; i < 255; i++) begin
      if (ib + i < b_q.size()) begin
        if (b_q[ib + i] !== ks[254 - i]) nb_err++;
        if (b_q[ib + i] === 1'b1) ones++;
      end else begin
        nb_err++;
      end
    end
    checkOutput({v.name, " iter_b sequence errors"}, nb_err, 0);
    if (v.exp_ones >= 0) checkOutput({v.name, " iter_b ones"}, ones, v.exp_ones);
    checkOutput({v.name, " first iter_b"}, (ib < b_q.size()) ? b_q[ib] : 1'bx, v.exp_first);
    checkOutput({v.name, " last iter_b"}, (ib + 254 < b_q.size()) ? b_q[ib + 254] : 1'bx, v.exp_last);
    checkOutput({v.name, " out_valid cycle"}, ov_cyc - en_cyc, 255 * (v.lat + 1) + 1);
    checkOutput({v.name, " busy cycles"}, busy_count - bb, 255 * (v.lat + 1));
    checkOutput({v.name, " busy at out_valid"}, busy_at_ov, 0);
    checkOutput({v.name, " seed xzm"}, (ib < xin_q.size()) ? xin_q[ib] : 'x, {256'd0, 256'd1});
    checkOutput({v.name, " seed xzm1"}, (ib < x1in_q.size()) ? x1in_q[ib] : 'x, {256'd1, v.wl[255:0]});
    checkOutput({v.name, " iter_work_low"}, (ib < wl_q.size()) ? wl_q[ib] : 'x, v.wl);
    checkOutput({v.name, " inputs stable in WAIT"}, stab_viol - sv, 0);
    if (v.mode != 2) checkOutput({v.name, " xzm_out"}, xzm_out, v.exp_xzm);
  endtask

  int ib2, bb2, ob2, guard;
  logic [255:0] tmp, k_rfc, u_rfc, exp_u, got_u;

  initial begin
    vecs[0] = '{"zero", 256'd0, 264'h09, 4, 0, 0, 1'b0, 1'b0, {256'd0, 256'd1}, -1, 0};
    vecs[1] = '{"bitorder", (256'd1 << 254) | 256'd1, {8'hA5, 256'h09}, 1, 0, 2, 1'b1, 1'b1,
                {256'd0, 256'd1}, -1, 1};
    vecs[2] = '{"allones", {256{1'b1}}, {8'h00, {8{32'h12345678}}}, 2, 1, 255, 1'b1, 1'b1,
                {256'd0, 256'd256}, -1, 0};
    vecs[3] = '{"bit255only", 256'd1 << 255, 264'h1234, 3, 1, 0, 1'b0, 1'b0, {256'd0, 256'd256}, -1, 0};
    vecs[4] = '{"alternating", {64{4'h5}}, 264'h77, 1, 0, 128, 1'b1, 1'b1, {256'd0, 256'd1}, 50, 0};
`ifdef X25519_CLAMP_EN
    vecs[0].exp_ones = 1;   vecs[0].exp_first = 1'b1; vecs[0].exp_last = 1'b0;
    vecs[1].exp_ones = 1;   vecs[1].exp_first = 1'b1; vecs[1].exp_last = 1'b0;
    vecs[2].exp_ones = 252; vecs[2].exp_first = 1'b1; vecs[2].exp_last = 1'b0;
    vecs[3].exp_ones = 1;   vecs[3].exp_first = 1'b1; vecs[3].exp_last = 1'b0;
    vecs[4].exp_ones = 126; vecs[4].exp_first = 1'b1; vecs[4].exp_last = 1'b0;
`endif

    rst = 1'b1; en = 1'b0; e = 256'd0; work_low = 264'd0;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset iter_en", iter_en, 0);
    checkOutput("reset iter_b", iter_b, 0);
    checkOutput("reset xzm_out", xzm_out, 0);
    checkOutput("reset iter_xzm_in", iter_xzm_in, 0);
    checkOutput("reset iter_xzm1_in", iter_xzm1_in, 0);
    checkOutput("reset iter_work_low", iter_work_low, 0);

    for (int i = 0; i < 5; i++) begin
      $display("[TB] vector %s", vecs[i].name);
      applyStimulus(vecs[i]);
    end

    // Reset during WAIT of iteration 100, then stale results must be dropped.
    $display("[TB] reset during WAIT with stale result");
    lat = 6; mode = 0;
    ib2 = issue_count;
    e = {256{1'b1}}; work_low = 264'h09; en = 1'b1;
    @(negedge clk); #1;
    en = 1'b0;
    guard = 0;
    while ((issue_count - ib2) < 101 && guard < 2000) begin
      @(negedge clk); #1;
      guard++;
    end
    checkOutput("reset test reached iteration 100", issue_count - ib2, 101);
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    ib2 = issue_count; bb2 = busy_count; ob2 = ov_count;
    @(negedge clk); #1;
    stale_req++;
    repeat (10) begin
      @(negedge clk); #1;
    end
    checkOutput("after reset iter_en pulses", issue_count - ib2, 0);
    checkOutput("after reset busy cycles", busy_count - bb2, 0);
    checkOutput("after reset out_valid pulses", ov_count - ob2, 0);
    checkOutput("after reset stale not captured xzm", iter_xzm_in, 0);
    checkOutput("after reset stale not captured xzm1", iter_xzm1_in, 0);
    checkOutput("after reset xzm_out", xzm_out, 0);
    ve = vecs[1];
    ve.name = "run after reset";
    applyStimulus(ve);

    // RFC 7748 vector through the reference ladder, with an en pulse while busy.
    $display("[TB] RFC 7748 end to end");
    tmp = 256'ha546e36bf0527c9d3b16154b82465edd62144c0ac1fc5a18506a2244ba449ac4;
    k_rfc = bswap(tmp);
    k_rfc[2:0] = 3'b000; k_rfc[255] = 1'b0; k_rfc[254] = 1'b1;
    tmp = 256'he6db6867583030db3594c1a424b15f7c726624ec26b3353b10a903a6d0ab1c4c;
    u_rfc = bswap(tmp);
    u_rfc[255] = 1'b0;
    tmp = 256'hc3da55379de9c6908e94ea4df28d084f32eccf03491c71f754b4075577a28552;
    exp_u = bswap(tmp);
    ve = '{"rfc7748", k_rfc, {8'h00, u_rfc}, 2, 2, -1, 1'b1, 1'b0, 512'd0, 100, 0};
    applyStimulus(ve);
    got_u = fmul(xzm_out[255:0], finv(xzm_out[511:256]));
    checkOutput("rfc7748 u-coordinate", got_u, exp_u);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/x25519_ladder_control.md
# x25519_ladder_control

Sequencer for the full X25519 Montgomery ladder. It sits directly upstream of the single-step ladder iteration block and drives it once per scalar bit, from bit 254 down to bit 0, for 255 iterations. It seeds the projective points, feeds back each iteration's `(xzm, xzm1)` result with the next scalar bit, and hands the final `xzm` to the downstream reciprocal/final-multiply stage.

## Interface

Parameters: none.

Ports:
- `clk`  in  1  — sole clock.
- `rst`  in  1  — reset; synchronous, active-high.
- `en`  in  1  — start pulse; samples `e` and `work_low`.
- `e`  in  256  — scalar, little-endian bits (bit 0 = LSB of byte 0).
- `work_low`  in  264  — input u-coordinate field element.
- `busy`  out  1  — high from the cycle after an accepted `en` until the cycle `out_valid` is high.
- `out_valid`  out  1  — one-cycle pulse; `xzm_out` is valid.
- `xzm_out`  out  512  — final `{z[255:0], x[255:0]}`; held until the next accepted `en`.
- `iter_en`  out  1  — start pulse to the iteration block.
- `iter_xzm_in`  out  512  — current `xzm`.
- `iter_xzm1_in`  out  512  — current `xzm1`.
- `iter_b`  out  1  — current scalar bit; stable from `iter_en` until `iter_out_valid`.
- `iter_work_low`  out  264  — latched `work_low`.
- `iter_out_valid`  in  1  — iteration result valid.
- `iter_xzm_out`  in  512  — iteration result `xzm`.
- `iter_xzm1_out`  in  512  — iteration result `xzm1`.

## Operation

- State machine: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - `en`: latch `e` (clamped if configured) and `work_low`.
  - Initialise `xzm = {256'd0, 256'd1}` and `xzm1 = {256'd1, work_low[255:0]}`.
  - Set `pos = 254` and go to ISSUE.
- **ISSUE**
  - Assert `iter_en` for one cycle, with `iter_b = e[pos]`, then go to WAIT.
- **WAIT**
  - On `iter_out_valid`, capture `iter_xzm_out` and `iter_xzm1_out` into `xzm` and `xzm1`.
  - If `pos == 0`, go to DONE; otherwise decrement `pos` and go to ISSUE.
- **DONE**
  - Drive `xzm_out = xzm`, pulse `out_valid`, deassert `busy`, return to IDLE.
- `pos` is 8 bits and never wraps: the terminal test is `pos == 0` before the decrement.
- `e[255]` is never consumed.
- `iter_xzm_in`, `iter_xzm1_in` and `iter_work_low` are registered and remain constant while in WAIT.
- Iteration count per operation is exactly 255.
- Boundary conditions:
  - `en` while `busy` is ignored. The latched scalar, state and counter are unchanged.
  - `iter_out_valid` in IDLE, ISSUE or DONE is discarded. This covers stale results arriving after a reset, because the iteration block has no reset.
  - `en` in the same cycle as DONE is ignored; `en` is accepted from the following IDLE cycle.
  - `rst` at any point: go to IDLE the next cycle and clear `pos`, `busy` and `out_valid`. Any in-flight iteration result is dropped.

## Timing

- Reset values:
  - `busy = 0`, `out_valid = 0`, `iter_en = 0`, `iter_b = 0`.
  - `xzm_out = 0`, `iter_xzm_in = 0`, `iter_xzm1_in = 0`, `iter_work_low = 0`.
  - State is IDLE.
- Accepted `en` at cycle 0: ISSUE at cycle 1, so the first `iter_en` is at cycle 1.
- `iter_out_valid` at cycle t: next `iter_en` at t+1, or `out_valid` at t+1 after the last iteration.
- With an iteration latency of L cycles (from `iter_en` to `iter_out_valid`):
  - iteration k issues at 1+k(L+1);
  - `out_valid` is at cycle 255(L+1)+1.
- `busy` rises at cycle 1 and falls with `out_valid`.
- `xzm_out` updates in the same cycle as `out_valid`.

## Configuration

- `X25519_CLAMP_EN` defined:
  - the latched scalar is the RFC 7748 clamp of `e`: bits 0, 1, 2 and 255 cleared, bit 254 set;
  - the first `iter_b` is therefore always 1.
- `X25519_CLAMP_EN` undefined: `e` is latched unmodified and the caller is responsible for clamping.

## Test plan

- **Iteration count and latency:** stub iteration with L=4 returning inputs unchanged, `en` at cycle 0, `e = 0`, macro undefined -> exactly 255 `iter_en` pulses, all `iter_b = 0`; `out_valid` at cycle 1276; `xzm_out = {256'd0, 256'd1}`.
- **Bit order:** `e = 256'h1 << 254 | 256'h1`, macro undefined -> `iter_b` sequence is 1, then 253 zeros, then 1.
- **Clamping:** `e = 256'hFF..FF` with macro defined -> 255 pulses; `iter_b` is 1 for the first 252 iterations and 0 for the last 3. With `e = 0` -> first `iter_b` is 1, the rest 0.
- **Seeding:** `work_low = 264'h09` -> first issue has `iter_xzm1_in = {256'd1, 256'h09}` and `iter_xzm_in = {256'd0, 256'd1}`.
- **Reset and stale results:** assert `rst` during WAIT of iteration 100, then inject `iter_out_valid` 3 cycles later -> no capture, no `iter_en`, `busy = 0`. A new `en` then produces a full 255-iteration run.
- **End to end and busy:** real iteration block, RFC 7748 vector (scalar a546e36b…, u-coordinate e6db6867…) -> `xzm_out` x/z consistent with the expected u after inversion. A second `en` pulsed while `busy` is ignored.
